// File: rtl/pipe_shifter_pkg.sv
// Shared types and stage-planning helpers for the pipelined barrel shifter.
// The shift is built from log2(WIDTH) power-of-two steps; these helpers decide
// which steps each pipeline stage owns (extra steps go to the earliest stages).
package shifter_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_op_e;

    // Number of power-of-two steps owned by pipeline stage `stage`.
    function automatic int num_steps(input int stage, input int stages, input int total);
        int base;
        int rem;
        base = total / stages;
        rem  = total % stages;
        return base + ((stage < rem) ? 1 : 0);
    endfunction

    // Index of the first power-of-two step owned by pipeline stage `stage`.
    function automatic int first_step(input int stage, input int stages, input int total);
        int base;
        int rem;
        base = total / stages;
        rem  = total % stages;
        return stage * base + ((stage < rem) ? stage : rem);
    endfunction

endpackage

// File: rtl/pipe_shifter_shift_step.sv
// One combinational power-of-two slice of the barrel shifter.
// When enabled it shifts/rotates by SHIFT and reports the last bit moved out
// as the carry; when disabled value and carry pass through untouched, so a
// chain of slices yields the architectural carry of the whole shift.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHIFT = 1
) (
    input  shift_op_e          op,
    input  logic               en,
    input  logic [WIDTH-1:0]   val_in,
    input  logic               cin,
    output logic [WIDTH-1:0]   val_out,
    output logic               cout
);

    // Conditional shift by SHIFT with carry tracking.
    always_comb begin
        val_out = val_in;
        cout    = cin;
        if (en) begin
            case (op)
                SH_LSL: begin
                    val_out = val_in << SHIFT;
                    cout    = val_in[WIDTH-SHIFT];
                end
                SH_LSR: begin
                    val_out = val_in >> SHIFT;
                    cout    = val_in[SHIFT-1];
                end
                SH_ASR: begin
                    val_out = $signed(val_in) >>> SHIFT;
                    cout    = val_in[SHIFT-1];
                end
                default: begin
                    // Rotate right; new MSB is the bit rotated round.
                    val_out = {val_in[SHIFT-1:0], val_in[WIDTH-1:SHIFT]};
                    cout    = val_in[SHIFT-1];
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined ARM-style barrel shifter (LSL/LSR/ASR/ROR/RRX) with shifter
// carry-out, elastic valid/ready handshake, flush and a pass-through tag.
// Optional feature macro: SHIFTER_RRX_EN (immediate ROR #0 becomes RRX).
module pipe_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int AMT_W  = 8,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic               in_imm,
    input  logic [AMT_W-1:0]   in_amt,
    input  logic [WIDTH-1:0]   in_val,
    input  logic               in_cin,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_res,
    output logic               out_cout,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int              LOG_W = $clog2(WIDTH);
    localparam logic [AMT_W:0]  W_AMT = (AMT_W+1)'(WIDTH);

    if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("pipe_shifter: WIDTH must be a power of two >= 8");
    end
    if (STAGES < 1 || STAGES > LOG_W) begin : g_bad_stages
        $error("pipe_shifter: STAGES must be in 1..$clog2(WIDTH)");
    end
    if (AMT_W <= LOG_W) begin : g_bad_amt
        $error("pipe_shifter: AMT_W must be able to hold WIDTH");
    end

    // Per-stage payload. Kept local because its widths follow the parameters.
    typedef struct packed {
        logic               valid;
        shift_op_e          op;
        logic               rrx;
        logic               oor;
        logic [AMT_W-1:0]   amt;
        logic [WIDTH-1:0]   val;
        logic               cin;
        logic [TAG_W-1:0]   tag;
    } stage_t;

    stage_t dec;
    stage_t stg_in [STAGES];
    logic   advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stage-0 decode: immediate remap, RRX marking and out-of-range detection.
    always_comb begin
        dec       = '0;
        dec.valid = in_valid;
        dec.op    = shift_op_e'(in_op);
        dec.amt   = in_amt;
        dec.val   = in_val;
        dec.cin   = in_cin;
        dec.tag   = in_tag;
        if (in_imm && in_amt == '0) begin
            case (dec.op)
                SH_LSR, SH_ASR: dec.amt = AMT_W'(WIDTH);
`ifdef SHIFTER_RRX_EN
                SH_ROR:         dec.rrx = 1'b1;
`endif
                default: ;
            endcase
        end
        // Rotates wrap modulo WIDTH, so only the linear shifts can go out of range.
        dec.oor = (dec.op != SH_ROR) && ({1'b0, dec.amt} >= W_AMT);
    end

    assign stg_in[0] = dec;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int NS = num_steps(s, STAGES, LOG_W);
        localparam int FS = first_step(s, STAGES, LOG_W);

        logic [WIDTH-1:0] v [NS+1];
        logic             c [NS+1];

        assign v[0] = stg_in[s].val;
        assign c[0] = stg_in[s].cin;

        // Out-of-range ops skip every step so the original operand reaches the
        // final stage, where the saturated result is selected from it.
        for (genvar j = 0; j < NS; j++) begin : g_step
            shift_step #(
                .WIDTH (WIDTH),
                .SHIFT (1 << (FS + j))
            ) u_step (
                .op      (stg_in[s].op),
                .en      (stg_in[s].amt[FS+j] && !stg_in[s].oor),
                .val_in  (v[j]),
                .cin     (c[j]),
                .val_out (v[j+1]),
                .cout    (c[j+1])
            );
        end

        if (s < STAGES - 1) begin : g_mid
            stage_t q;

            // Intermediate stage register; flush only drops the valid bit.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    q <= '0;
                end else if (flush) begin
                    q.valid <= 1'b0;
                end else if (advance) begin
                    q     <= stg_in[s];
                    q.val <= v[NS];
                    q.cin <= c[NS];
                end
            end

            assign stg_in[s+1] = q;
        end else begin : g_last
            logic [WIDTH-1:0] fin_val;
            logic             fin_cout;

            // Resolve RRX, out-of-range and rotate-by-multiple-of-WIDTH cases.
            always_comb begin
                fin_val  = v[NS];
                fin_cout = c[NS];
                if (stg_in[s].rrx) begin
                    fin_val  = {stg_in[s].cin, stg_in[s].val[WIDTH-1:1]};
                    fin_cout = stg_in[s].val[0];
                end else if (stg_in[s].oor) begin
                    case (stg_in[s].op)
                        SH_LSL: begin
                            fin_val  = '0;
                            fin_cout = (stg_in[s].amt == AMT_W'(WIDTH)) ?
                                       stg_in[s].val[0] : 1'b0;
                        end
                        SH_LSR: begin
                            fin_val  = '0;
                            fin_cout = (stg_in[s].amt == AMT_W'(WIDTH)) ?
                                       stg_in[s].val[WIDTH-1] : 1'b0;
                        end
                        SH_ASR: begin
                            fin_val  = {WIDTH{stg_in[s].val[WIDTH-1]}};
                            fin_cout = stg_in[s].val[WIDTH-1];
                        end
                        default: ;
                    endcase
                end else if (stg_in[s].op == SH_ROR && stg_in[s].amt != '0 &&
                             stg_in[s].amt[LOG_W-1:0] == '0) begin
                    fin_cout = stg_in[s].val[WIDTH-1];
                end
            end

            // Output register; flush only drops the valid bit.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    out_valid <= 1'b0;
                    out_res   <= '0;
                    out_cout  <= 1'b0;
                    out_tag   <= '0;
                end else if (flush) begin
                    out_valid <= 1'b0;
                end else if (advance) begin
                    out_valid <= stg_in[s].valid;
                    out_res   <= fin_val;
                    out_cout  <= fin_cout;
                    out_tag   <= stg_in[s].tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_shifter.sv
// Scoreboard bench for pipe_shifter: random and directed stimulus, expected
// results from a behavioural model pushed on acceptance, popped on output.
module tb_pipe_shifter;

    localparam int WIDTH  = 32;
    localparam int AMT_W  = 8;
    localparam int STAGES = 2;
    localparam int TAG_W  = 4;
    localparam int EXP_W  = TAG_W + 1 + WIDTH;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               flush = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [1:0]         in_op = '0;
    logic               in_imm = 1'b0;
    logic [AMT_W-1:0]   in_amt = '0;
    logic [WIDTH-1:0]   in_val = '0;
    logic               in_cin = 1'b0;
    logic [TAG_W-1:0]   in_tag = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [WIDTH-1:0]   out_res;
    logic               out_cout;
    logic [TAG_W-1:0]   out_tag;

    int n_pass  = 0;
    int n_total = 0;
    logic [EXP_W-1:0] sb_q [$];

    pipe_shifter #(
        .WIDTH  (WIDTH),
        .AMT_W  (AMT_W),
        .STAGES (STAGES),
        .TAG_W  (TAG_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_imm    (in_imm),
        .in_amt    (in_amt),
        .in_val    (in_val),
        .in_cin    (in_cin),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_cout  (out_cout),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference shifter: returns {carry, result}, written from the ARM rules.
    function automatic logic [WIDTH:0] ref_shift(input logic [1:0] op, input logic imm,
                                                 input logic [AMT_W-1:0] amt,
                                                 input logic [WIDTH-1:0] val, input logic cin);
        int unsigned n;
        int unsigned r;
        logic [2*WIDTH-1:0]        t;
        logic signed [2*WIDTH-1:0] ts;
        logic [WIDTH-1:0]          res;
        logic                      c;
        n   = amt;
        res = val;
        c   = cin;
        if (imm && amt == 0) begin
            if (op == 2'b01 || op == 2'b10) n = WIDTH;
`ifdef SHIFTER_RRX_EN
            if (op == 2'b11) return {val[0], cin, val[WIDTH-1:1]};
`endif
        end
        if (n != 0) begin
            case (op)
                2'b00: if (n < WIDTH) begin
                    t = {{WIDTH{1'b0}}, val} << n;
                    res = t[WIDTH-1:0];
                    c = t[WIDTH];
                end else begin
                    res = '0;
                    c = (n == WIDTH) ? val[0] : 1'b0;
                end
                2'b01: if (n < WIDTH) begin
                    t = {val, {WIDTH{1'b0}}} >> n;
                    res = t[2*WIDTH-1:WIDTH];
                    c = t[WIDTH-1];
                end else begin
                    res = '0;
                    c = (n == WIDTH) ? val[WIDTH-1] : 1'b0;
                end
                2'b10: if (n < WIDTH) begin
                    ts = $signed({val, {WIDTH{1'b0}}}) >>> n;
                    res = ts[2*WIDTH-1:WIDTH];
                    c = ts[WIDTH-1];
                end else begin
                    res = {WIDTH{val[WIDTH-1]}};
                    c = val[WIDTH-1];
                end
                default: begin
                    r = n % WIDTH;
                    if (r == 0) c = val[WIDTH-1];
                    else begin
                        res = (val >> r) | (val << (WIDTH - r));
                        c = res[WIDTH-1];
                    end
                end
            endcase
        end
        return {c, res};
    endfunction

    // Recorder: the op on the inputs is accepted at the next rising edge.
    always @(negedge clk) begin
        #1;
        if (!reset || flush) sb_q.delete();
        else if (in_valid && in_ready)
            sb_q.push_back({in_tag, ref_shift(in_op, in_imm, in_amt, in_val, in_cin)});
    end

    // Monitor: every output handshake must match the oldest expected entry.
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected: got tag/c/res 0x%0h with no op outstanding",
                         {out_tag, out_cout, out_res});
            end else begin
                e = sb_q.pop_front();
                check("sb_result", 64'({out_tag, out_cout, out_res}), 64'(e));
            end
        end
    end

    task automatic rand_fields();
        in_op  = 2'($urandom_range(0, 3));
        in_imm = ($urandom_range(0, 3) == 0);
        case ($urandom_range(0, 7))
            0: in_amt = '0;
            1: in_amt = AMT_W'(1);
            2: in_amt = AMT_W'(WIDTH - 1);
            3: in_amt = AMT_W'(WIDTH);
            4: in_amt = AMT_W'(WIDTH + 1);
            5: in_amt = AMT_W'(2 * WIDTH);
            default: in_amt = AMT_W'($urandom_range(0, (1 << AMT_W) - 1));
        endcase
        in_val = WIDTH'($urandom());
        if ($urandom_range(0, 4) == 0) in_val = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
        in_cin = 1'($urandom_range(0, 1));
        in_tag = TAG_W'($urandom_range(0, (1 << TAG_W) - 1));
    endtask

    // Present one op (called just after a rising edge) and hold until accepted.
    task automatic send_rand();
        logic acc;
        rand_fields();
        in_valid = 1'b1;
        acc = 1'b0;
        for (int g = 0; g < 200 && !acc; g++) begin
            @(negedge clk);
            acc = in_ready && !flush && reset;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_total++;
            $display("FAIL send_timeout: op not accepted within 200 cycles");
        end
        in_valid = 1'b0;
    endtask

    // One op into an empty pipe with out_ready high; result due after STAGES edges.
    task automatic run_directed(input string name, input logic [1:0] op, input logic imm,
                                input logic [AMT_W-1:0] amt, input logic [WIDTH-1:0] val,
                                input logic cin, input logic [WIDTH-1:0] er, input logic ec);
        @(posedge clk);
        #1;
        in_op = op; in_imm = imm; in_amt = amt; in_val = val; in_cin = cin;
        in_tag = TAG_W'($urandom_range(0, (1 << TAG_W) - 1));
        in_valid = 1'b1;
        for (int i = 1; i <= STAGES; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (i < STAGES) check({name, "_early"}, 64'(out_valid), 64'(0));
        end
        check({name, "_latency"}, 64'(out_valid), 64'(1));
        check({name, "_res"}, 64'(out_res), 64'(er));
        check({name, "_cout"}, 64'(out_cout), 64'(ec));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        for (int i = 0; i < 60 && (sb_q.size() != 0 || out_valid); i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 64'(sb_q.size()), 64'(0));
    endtask

    initial begin
        logic pending;
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_out_res", 64'(out_res), 64'(0));
        check("reset_out_cout", 64'(out_cout), 64'(0));
        check("reset_out_tag", 64'(out_tag), 64'(0));
        out_ready = 1'b1;
        #1;
        check("reset_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Directed boundary cases.
        run_directed("lsl1", 2'b00, 1'b0, 8'd1, 32'h8000_0001, 1'b0, 32'h0000_0002, 1'b1);
        run_directed("lsr32", 2'b01, 1'b0, 8'd32, 32'h8000_0000, 1'b0, 32'h0, 1'b1);
        run_directed("lsr33", 2'b01, 1'b0, 8'd33, 32'h8000_0000, 1'b1, 32'h0, 1'b0);
        run_directed("asr_imm0", 2'b10, 1'b1, 8'd0, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1);
        run_directed("ror64", 2'b11, 1'b0, 8'd64, 32'h8000_0001, 1'b0, 32'h8000_0001, 1'b1);
        run_directed("lsl32", 2'b00, 1'b0, 8'd32, 32'h0000_0001, 1'b0, 32'h0, 1'b1);
        run_directed("lsl_reg0", 2'b00, 1'b0, 8'd0, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1);
        run_directed("ror4", 2'b11, 1'b0, 8'd4, 32'h0000_0018, 1'b0, 32'h8000_0001, 1'b1);
`ifdef SHIFTER_RRX_EN
        run_directed("rrx", 2'b11, 1'b1, 8'd0, 32'h0000_0003, 1'b1, 32'h8000_0001, 1'b1);
`else
        run_directed("rrx", 2'b11, 1'b1, 8'd0, 32'h0000_0003, 1'b1, 32'h0000_0003, 1'b1);
`endif
        drain();

        // Random traffic with random back-pressure and occasional flush.
        pending = 1'b0;
        repeat (400) begin
            @(posedge clk);
            #1;
            if (!pending) begin
                if ($urandom_range(0, 9) < 8) begin
                    rand_fields();
                    in_valid = 1'b1;
                    pending = 1'b1;
                end else in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 29) == 0);
            @(negedge clk);
            if (in_valid && in_ready && !flush) pending = 1'b0;
        end
        @(posedge clk);
        #1;
        drain();

        // Back-pressure: 8 ops streamed, consumer stalls for 3 cycles mid-stream.
        @(posedge clk);
        #1;
        fork
            begin
                for (int k = 0; k < 8; k++) send_rand();
            end
            begin
                repeat (STAGES + 1) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready_low", 64'(in_ready), 64'(0));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Flush with a full pipe and a new op on the input.
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 0; k <= STAGES; k++) begin
            rand_fields();
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        check("flush_pipe_full", 64'(out_valid), 64'(1));
        rand_fields();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'(0));
        for (int k = 0; k <= STAGES; k++) begin
            @(posedge clk);
            #1;
            check("flush_dropped", 64'(out_valid), 64'(0));
        end
        drain();

        // Reset asserted mid-stream.
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            rand_fields();
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midreset_out_valid", 64'(out_valid), 64'(0));
        check("midreset_out_res", 64'(out_res), 64'(0));
        check("midreset_out_tag", 64'(out_tag), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        run_directed("post_reset", 2'b00, 1'b0, 8'd1, 32'h8000_0001, 1'b0, 32'h0000_0002, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
